// File: rtl/freq_detector_square_ext.sv
// freq_detector_square_ext: square-wave period meter with averaging, stability flag and loss-of-signal
// Measures the clk-cycle period between selected edges of signal_in, keeps a
// running-sum average over the last HIST_DEPTH periods and flags stability.
// Ports:
//   clk, rst_n     system clock, asynchronous active-low reset
//   en             measurement enable; low disarms and clears measurement state
//   edge_mode      00 rising, 01 falling, 10 both edges (half periods), 11 rising
//   signal_in      asynchronous square-wave input
//   period_out     last captured period; period_valid strobes for one cycle on capture
//   avg_period     mean of the last HIST_DEPTH periods; avg_valid once the window is full
//   stable         STABLE_CYCLES consecutive matching periods with a full window
//   signal_lost    no selected edge for TIMEOUT_CYCLES clk cycles
module freq_detector_square_ext #(
  parameter int CNT_W          = 18,
  parameter int HIST_DEPTH     = 4,
  parameter int THRESHOLD      = 1,
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       edge_mode,
  input  logic             signal_in,
  output logic [CNT_W-1:0] period_out,
  output logic             period_valid,
  output logic [CNT_W-1:0] avg_period,
  output logic             avg_valid,
  output logic             stable,
  output logic             signal_lost
);
  localparam int L   = $clog2(HIST_DEPTH);
  localparam int SW  = CNT_W + L;
  localparam int FW  = $clog2(HIST_DEPTH + 1);
  localparam int SCW = $clog2(STABLE_CYCLES + 1);

  typedef enum logic [1:0] {DISARMED, ARMED, RUN} state_t;

  state_t             state, state_nx;
  logic [2:0]         sync;
  logic [1:0]         mode_r;
  logic               sel, e;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   hist [HIST_DEPTH];
  logic [L-1:0]       ptr;
  logic [FW-1:0]      fill;
  logic [SW-1:0]      sum;
  logic [SCW-1:0]     stable_cnt;
  logic [CNT_W-1:0]   evicted;
  logic signed [CNT_W:0] diff;
  logic [CNT_W:0]     mag;
  logic               disarm, timeout, capture, compare, match, full;

  // sync[1:0] is the two-flop synchroniser, sync[2] the delay stage used for edge decode;
  // the decoded edge is registered once more so capture lands three clocks after sampling
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync   <= '0;
      e      <= 1'b0;
      mode_r <= 2'b00;
    end else begin
      sync   <= {sync[1:0], signal_in};
      e      <= sel;
      mode_r <= edge_mode;
    end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= DISARMED;
    else        state <= state_nx;

  always_comb begin
    state_nx = state;
    if (disarm || timeout) state_nx = DISARMED;
    else if (e)            state_nx = (state == DISARMED) ? ARMED : RUN;
  end

  always_comb begin
    sel     = (edge_mode == 2'b01) ? (!sync[1] && sync[2]) :
              (edge_mode == 2'b10) ? (sync[1] ^ sync[2]) :
                                     (sync[1] && !sync[2]);
    disarm  = !en || (edge_mode != mode_r);
    // an edge in the timeout cycle wins and is captured instead
    timeout = !disarm && (state != DISARMED) && !e && (count == CNT_W'(TIMEOUT_CYCLES));
    capture = !disarm && e && (state != DISARMED);
    compare = capture && (state == RUN);
    full    = (fill == FW'(HIST_DEPTH));
    evicted = full ? hist[ptr] : '0;
    // signed difference one bit wider than the counter so values near 0 or max never wrap
    diff    = $signed({1'b0, count}) - $signed({1'b0, period_out});
    mag     = diff[CNT_W] ? $unsigned(-diff) : $unsigned(diff);
    match   = (mag <= (CNT_W+1)'(THRESHOLD));
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      period_out   <= '0;
      period_valid <= 1'b0;
      avg_period   <= '0;
      avg_valid    <= 1'b0;
      stable       <= 1'b0;
      signal_lost  <= 1'b0;
      count        <= '0;
      ptr          <= '0;
      fill         <= '0;
      sum          <= '0;
      stable_cnt   <= '0;
      for (int i = 0; i < HIST_DEPTH; i++) hist[i] <= '0;
    end else begin
      period_valid <= capture;
      if (disarm || timeout) begin
        count       <= '0;
        ptr         <= '0;
        fill        <= '0;
        sum         <= '0;
        stable_cnt  <= '0;
        avg_valid   <= 1'b0;
        stable      <= 1'b0;
        signal_lost <= timeout || (en && signal_lost);
      end else begin
        // registered summary follows the cycle after each capture
        if (period_valid) begin
          avg_period <= sum[SW-1:L];
          avg_valid  <= full;
          stable     <= (stable_cnt == SCW'(STABLE_CYCLES)) && full;
        end
        if (e) begin
          count <= CNT_W'(1);
          if (state == DISARMED) signal_lost <= 1'b0;
        end else if (state != DISARMED) begin
          count <= count + 1'b1;
        end
        if (capture) begin
          period_out <= count;
          hist[ptr]  <= count;
          ptr        <= ptr + 1'b1;
          sum        <= sum + SW'(count) - SW'(evicted);
          fill       <= full ? fill : fill + 1'b1;
          if (compare)
            stable_cnt <= !match ? '0 :
                          (stable_cnt == SCW'(STABLE_CYCLES)) ? stable_cnt : stable_cnt + 1'b1;
        end
      end
    end
endmodule

// File: tb/tb_freq_detector_square_ext.sv
// tb_freq_detector_square_ext: vector table, corner sequences and random stimulus against a cycle-level model
module tb_freq_detector_square_ext;
  localparam int CW = 18;
  localparam int HD = 4;
  localparam int TH = 1;
  localparam int SC = 4;
  localparam int TO = 500;

  logic          clk, rst_n, en, signal_in;
  logic [1:0]    edge_mode;
  logic [CW-1:0] period_out, avg_period;
  logic          period_valid, avg_valid, stable, signal_lost;

  freq_detector_square_ext #(
    .CNT_W(CW), .HIST_DEPTH(HD), .THRESHOLD(TH), .STABLE_CYCLES(SC), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .edge_mode(edge_mode), .signal_in(signal_in),
    .period_out(period_out), .period_valid(period_valid), .avg_period(avg_period),
    .avg_valid(avg_valid), .stable(stable), .signal_lost(signal_lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int pv_cnt = 0;

  task automatic chk(string nm, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // Reference model: each selected transition takes effect 3 clocks after the clock that
  // sampled it; periods are differences of those effective times, kept in a sliding window.
  int   m_t, m_last, m_phase, m_run, m_po, m_ap;
  bit   m_pv, m_av, m_st, m_lost, m_pend;
  bit   smp [5];
  logic [1:0] m_pm;
  int   win [$];

  function automatic bit sel_edge(logic [1:0] m, bit old_v, bit new_v);
    return (m == 2'b01) ? (old_v && !new_v) : (m == 2'b10) ? (old_v != new_v) : (!old_v && new_v);
  endfunction

  task automatic model_clear();
    m_phase = 0;
    m_run   = 0;
    m_av    = 0;
    m_st    = 0;
    win.delete();
  endtask

  task automatic model_step();
    bit ev, dis, pv;
    int per, wsum, d;
    if (!rst_n) begin
      model_clear();
      m_t = 0; m_last = 0; m_po = 0; m_ap = 0;
      m_pv = 0; m_lost = 0; m_pend = 0; m_pm = 2'b00;
      for (int i = 0; i < 5; i++) smp[i] = 0;
    end else begin
      m_t++;
      for (int i = 4; i > 0; i--) smp[i] = smp[i-1];
      smp[0] = signal_in;
      ev   = sel_edge(m_pm, smp[4], smp[3]);
      dis  = !en || (edge_mode != m_pm);
      m_pm = edge_mode;
      wsum = 0;
      foreach (win[i]) wsum += win[i];
      pv = 0;
      if (dis) begin
        model_clear();
        if (!en) m_lost = 0;
      end else if (m_phase != 0 && !ev && (m_t - m_last) == TO) begin
        model_clear();
        m_lost = 1;
      end else begin
        if (m_pend) begin
          m_ap = wsum / HD;
          m_av = (win.size() == HD);
          m_st = (m_run == SC) && m_av;
        end
        if (ev) begin
          if (m_phase == 0) begin
            m_phase = 1;
            m_last  = m_t;
            m_lost  = 0;
          end else begin
            per    = m_t - m_last;
            m_last = m_t;
            pv     = 1;
            if (m_phase == 2) begin
              d     = per - m_po;
              m_run = ((d < 0 ? -d : d) <= TH) ? ((m_run < SC) ? m_run + 1 : SC) : 0;
            end
            m_po = per;
            win.push_back(per);
            if (win.size() > HD) void'(win.pop_front());
            m_phase = 2;
          end
        end
      end
      m_pv   = pv;
      m_pend = pv;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    pv_cnt += int'(period_valid);
    chk("m_period_valid", period_valid, m_pv);
    chk("m_period_out",   period_out,   m_po);
    chk("m_avg_period",   avg_period,   m_ap);
    chk("m_avg_valid",    avg_valid,    m_av);
    chk("m_stable",       stable,       m_st);
    chk("m_signal_lost",  signal_lost,  m_lost);
  end

  task automatic wave(int hi, int lo, int n);
    for (int i = 0; i < n; i++) begin
      signal_in = 1'b1;
      repeat (hi) @(negedge clk);
      signal_in = 1'b0;
      repeat (lo) @(negedge clk);
    end
  endtask

  task automatic wait_pv(int lim, output int n, output bit found);
    n = 0;
    found = 0;
    while (!found && n < lim) begin
      @(negedge clk);
      n++;
      found = period_valid;
    end
  endtask

  typedef struct {
    logic [1:0] mode;
    int hi, lo, n;
    int po, ap;
    bit av, st;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int n, c0, bh, bl, r;
    bit found;
    tbl[0] = '{2'd0, 50, 50,  8, 100, 100, 1'b1, 1'b1};
    tbl[1] = '{2'd1, 40, 60,  8, 100, 100, 1'b1, 1'b1};
    tbl[2] = '{2'd2, 30, 70,  8,  30,  50, 1'b1, 1'b0};
    tbl[3] = '{2'd3, 60, 61,  8, 121, 121, 1'b1, 1'b1};
    tbl[4] = '{2'd2, 45, 46,  8,  45,  45, 1'b1, 1'b1};
    tbl[5] = '{2'd0,  1,  2, 10,   3,   3, 1'b1, 1'b1};

    rst_n = 1'b0; en = 1'b0; edge_mode = 2'b00; signal_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_period_out", period_out, 0);
    chk("reset_avg_period", avg_period, 0);
    chk("reset_flags", {period_valid, avg_valid, stable, signal_lost}, 0);
    rst_n = 1'b1; en = 1'b1;
    repeat (5) @(negedge clk);

    foreach (tbl[k]) begin
      edge_mode = tbl[k].mode;
      wave(tbl[k].hi, tbl[k].lo, tbl[k].n);
      repeat (8) @(negedge clk);
      chk($sformatf("tbl%0d_period_out", k), period_out, tbl[k].po);
      chk($sformatf("tbl%0d_avg_period", k), avg_period, tbl[k].ap);
      chk($sformatf("tbl%0d_avg_valid", k),  avg_valid,  tbl[k].av);
      chk($sformatf("tbl%0d_stable", k),     stable,     tbl[k].st);
    end

    // one long period knocks stable down for exactly one capture plus four matches
    wave(50, 50, 8);
    wave(53, 50, 1);
    chk("pre_jump_stable", stable, 1);
    signal_in = 1'b1;
    wait_pv(8, n, found);
    chk("pv_latency", n, 4);
    chk("jump_period", period_out, 103);
    chk("jump_stable_at_tp", stable, 1);
    @(negedge clk);
    chk("jump_stable_tp1", stable, 0);
    repeat (45) @(negedge clk);
    signal_in = 1'b0;
    repeat (50) @(negedge clk);
    wave(50, 50, 4);
    chk("three_matches_stable", stable, 0);
    wave(50, 50, 1);
    chk("four_matches_stable", stable, 1);

    for (int i = 0; i < 3; i++) begin
      wave(50, 50, 1); wave(50, 51, 1); wave(50, 50, 1); wave(50, 49, 1);
    end
    signal_in = 1'b1;
    repeat (10) @(negedge clk);
    chk("alt_avg", avg_period, 100);
    chk("alt_stable", stable, 1);
    chk("alt_avg_valid", avg_valid, 1);

    repeat (40) @(negedge clk);
    signal_in = 1'b0;
    repeat (50) @(negedge clk);
    signal_in = 1'b1;
    wait_pv(8, n, found);
    chk("pre_timeout_pv", found, 1);
    n = 0;
    while (!signal_lost && n < 700) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_cycles", n, TO);
    chk("timeout_stable", stable, 0);
    chk("timeout_avg_valid", avg_valid, 0);
    chk("timeout_avg_hold", avg_period, 100);
    chk("timeout_period_hold", period_out, 100);

    signal_in = 1'b0;
    repeat (50) @(negedge clk);
    c0 = pv_cnt;
    signal_in = 1'b1;
    repeat (10) @(negedge clk);
    chk("restart_lost_clear", signal_lost, 0);
    chk("restart_no_capture", pv_cnt - c0, 0);
    repeat (40) @(negedge clk);
    signal_in = 1'b0;
    repeat (50) @(negedge clk);
    signal_in = 1'b1;
    wait_pv(8, n, found);
    chk("restart_capture", found, 1);
    chk("restart_period", period_out, 100);
    repeat (45) @(negedge clk);
    signal_in = 1'b0;
    repeat (50) @(negedge clk);

    wave(50, 50, 2);
    signal_in = 1'b1;
    repeat (20) @(negedge clk);
    c0 = pv_cnt;
    edge_mode = 2'b01;
    @(negedge clk);
    edge_mode = 2'b00;
    repeat (29) @(negedge clk);
    signal_in = 1'b0;
    repeat (50) @(negedge clk);
    signal_in = 1'b1;
    repeat (20) @(negedge clk);
    chk("mode_toggle_no_pv", pv_cnt - c0, 0);
    chk("mode_toggle_avg_valid", avg_valid, 0);
    repeat (30) @(negedge clk);
    signal_in = 1'b0;
    repeat (50) @(negedge clk);
    signal_in = 1'b1;
    repeat (20) @(negedge clk);
    chk("mode_toggle_recapture", pv_cnt - c0, 1);

    c0 = pv_cnt;
    en = 1'b0;
    repeat (3) @(negedge clk);
    en = 1'b1;
    repeat (27) @(negedge clk);
    signal_in = 1'b0;
    repeat (50) @(negedge clk);
    signal_in = 1'b1;
    repeat (20) @(negedge clk);
    chk("en_pulse_no_pv", pv_cnt - c0, 0);
    repeat (30) @(negedge clk);
    signal_in = 1'b0;
    repeat (50) @(negedge clk);
    signal_in = 1'b1;
    repeat (20) @(negedge clk);
    chk("en_pulse_recapture", pv_cnt - c0, 1);

    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_period_out", period_out, 0);
    chk("rst_mid_avg_period", avg_period, 0);
    chk("rst_mid_flags", {period_valid, avg_valid, stable, signal_lost}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    signal_in = 1'b0;
    repeat (5) @(negedge clk);

    bh = 40; bl = 40;
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 19);
      if (r == 0) begin
        edge_mode = 2'($urandom_range(0, 3));
        @(negedge clk);
      end else if (r == 1) begin
        en = 1'b0;
        repeat ($urandom_range(1, 5)) @(negedge clk);
        en = 1'b1;
      end else if (r == 2) begin
        repeat ($urandom_range(480, 520)) @(negedge clk);
      end else if (r == 3) begin
        bh = $urandom_range(1, 60);
        bl = $urandom_range(1, 60);
      end else if (r < 6) begin
        wave($urandom_range(1, 70), $urandom_range(1, 70), 1);
      end else begin
        wave(bh + $urandom_range(0, 1), bl, 1);
      end
    end
    repeat (10) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
